// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction memory between the
// instruction-fetch port and a loader/debug port. Loader has priority, with a
// starvation counter that forces a fetch grant after STARVE_MAX loader wins.
// Grants and memory controls are combinational; responses come out exactly
// one cycle after the grant, aligned with the memory's registered read data.
module imem_arbiter #(
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [31:0]       f_inst,
  output logic              f_err,
  // loader / debug port
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_valid,
  output logic [31:0]       l_rdata,
  output logic              l_err,
  // memory port
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [31:0]      DEPTH_W    = 32'(DEPTH);

  localparam logic [1:0] RSP_IDLE  = 2'd0;
  localparam logic [1:0] RSP_FETCH = 2'd1;
  localparam logic [1:0] RSP_LOAD  = 2'd2;

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]       rsp_q, rsp_d;
  logic             err_q, err_d;
  logic             wr_q, wr_d;

  logic             f_win;
  logic             f_ok;
  logic             l_ok;

  // Address range checks against the memory depth.
  always_comb begin
    f_ok = (f_addr < DEPTH_W);
    l_ok = (l_addr < DEPTH_W);
  end

  // Arbitration: loader first unless fetch has been starved long enough.
  always_comb begin
    f_win = f_req && (!l_req || (starve_cnt_q == STARVE_LIM));
    f_gnt = rst_n && f_win;
    l_gnt = rst_n && l_req && !f_win;
  end

  // Memory control for the granted requester; out-of-range grants never reach memory.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (l_gnt) begin
      m_en    = l_ok;
      m_we    = l_ok && l_we;
      m_addr  = ADDR_W'(l_addr);
      m_wdata = l_wdata;
    end else if (f_gnt) begin
      m_en    = f_ok;
      m_addr  = ADDR_W'(f_addr);
      m_wdata = l_wdata;
    end
  end

  // Arbitration and response state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q        <= RSP_IDLE;
      err_q        <= 1'b0;
      wr_q         <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      rsp_q        <= rsp_d;
      err_q        <= err_d;
      wr_q         <= wr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next response owner follows this cycle's grant; starvation counter update.
  always_comb begin
    rsp_d        = RSP_IDLE;
    err_d        = 1'b0;
    wr_d         = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (l_gnt) begin
      rsp_d = RSP_LOAD;
      err_d = !l_ok;
      wr_d  = l_we;
    end else if (f_gnt) begin
      rsp_d = RSP_FETCH;
      err_d = !f_ok;
    end
    if (f_gnt || !f_req) begin
      starve_cnt_d = '0;
    end else if (l_gnt && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Response outputs; reset blanks any in-flight response immediately.
  always_comb begin
    f_valid = rst_n && (rsp_q == RSP_FETCH);
    l_valid = rst_n && (rsp_q == RSP_LOAD);
    f_err   = f_valid && err_q;
    l_err   = l_valid && err_q;
    f_inst  = (f_valid && !err_q) ? m_rdata : 32'd0;
    l_rdata = (l_valid && !err_q && !wr_q) ? m_rdata : 32'd0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: vector table plus hand-written multi-cycle sequences,
// with a simple synchronous memory model behind the arbiter.
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req, f_gnt, f_valid, f_err;
  logic [31:0] f_addr, f_inst;
  logic        l_req, l_we, l_gnt, l_valid, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        m_en, m_we;
  logic [6:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [128];

  imem_arbiter #(.DEPTH(128), .ADDR_W(7), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
    .f_inst(f_inst), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_valid(l_valid), .l_rdata(l_rdata), .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory: registered read, write visible next cycle.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        lr;
    logic        lwe;
    logic [31:0] la;
    logic [31:0] lwd;
    logic [7:0]  ctl;   // {f_gnt,l_gnt,m_en,m_we,f_valid,f_err,l_valid,l_err}
    logic [31:0] fi;
    logic [31:0] lrd;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic fr, logic [31:0] fa, logic lr, logic lwe,
                              logic [31:0] la, logic [31:0] lwd, logic [7:0] ctl,
                              logic [31:0] fi, logic [31:0] lrd);
    vec_t v;
    v.fr = fr; v.fa = fa; v.lr = lr; v.lwe = lwe; v.la = la; v.lwd = lwd;
    v.ctl = ctl; v.fi = fi; v.lrd = lrd;
    return v;
  endfunction

  function automatic logic [7:0] ctl_now();
    return {f_gnt, l_gnt, m_en, m_we, f_valid, f_err, l_valid, l_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic lwe, input logic [31:0] la, input logic [31:0] lwd);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Loader reads addr 10 every cycle, fetch of addr 1 follows fmask; checks grants and responses.
  task automatic run_pat(input string nm, input logic [15:0] fmask,
                         input logic [15:0] exp_f, input int n);
    logic pf, pl, ef, el;
    pf = 1'b0;
    pl = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) drive(fmask[i], 32'd1, 1'b1, 1'b0, 32'd10, 32'd0);
      else       drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      ef = (i < n) && exp_f[i];
      el = (i < n) && !exp_f[i];
      @(negedge clk);
      chk($sformatf("%s_c%0d_gv", nm, i), 32'({f_gnt, l_gnt, f_valid, l_valid}),
          32'({ef, el, pf, pl}));
      chk($sformatf("%s_c%0d_fi", nm, i), f_inst, pf ? 32'hA000_0001 : 32'd0);
      chk($sformatf("%s_c%0d_lrd", nm, i), l_rdata, pl ? 32'hA000_000A : 32'd0);
      pf = ef;
      pl = el;
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0]  = 32'h8c06_0000;
    m_rdata = 32'd0;

    // ctl order: fg lg men mwe fv fe lv le
    vecs[0]  = mk(1, 32'd0,   0, 0, 32'd0,   32'd0,         8'b1010_0000, 32'd0,         32'd0);
    vecs[1]  = mk(0, 32'd0,   1, 1, 32'd2,   32'h0066_1820, 8'b0111_1000, 32'h8c06_0000, 32'd0);
    vecs[2]  = mk(1, 32'd2,   0, 0, 32'd0,   32'd0,         8'b1010_0010, 32'd0,         32'd0);
    vecs[3]  = mk(0, 32'd0,   1, 0, 32'd0,   32'd0,         8'b0110_1000, 32'h0066_1820, 32'd0);
    vecs[4]  = mk(1, 32'd128, 0, 0, 32'd0,   32'd0,         8'b1000_0010, 32'd0,         32'h8c06_0000);
    vecs[5]  = mk(0, 32'd0,   1, 1, 32'd200, 32'hDEAD_BEEF, 8'b0100_1100, 32'd0,         32'd0);
    vecs[6]  = mk(0, 32'd0,   1, 0, 32'd128, 32'd0,         8'b0100_0011, 32'd0,         32'd0);
    vecs[7]  = mk(0, 32'd0,   0, 0, 32'd0,   32'd0,         8'b0000_0011, 32'd0,         32'd0);
    vecs[8]  = mk(0, 32'd0,   1, 0, 32'd5,   32'd0,         8'b0110_0000, 32'd0,         32'd0);
    vecs[9]  = mk(1, 32'd127, 0, 0, 32'd0,   32'd0,         8'b1010_0010, 32'd0,         32'hA000_0005);
    vecs[10] = mk(0, 32'd0,   0, 0, 32'd0,   32'd0,         8'b0000_1000, 32'hA000_007F, 32'd0);
    vecs[11] = mk(0, 32'd0,   0, 0, 32'd0,   32'd0,         8'b0000_0000, 32'd0,         32'd0);

    // Reset with both requesters active: everything must stay quiet.
    rst_n = 1'b0;
    drive(1'b1, 32'd0, 1'b1, 1'b1, 32'd3, 32'h1234_5678);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 32'(ctl_now()), 32'd0);
    chk("rst_fi", f_inst, 32'd0);
    chk("rst_lrd", l_rdata, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lwe, vecs[i].la, vecs[i].lwd);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_fi", i), f_inst, vecs[i].fi);
      chk($sformatf("vec%0d_lrd", i), l_rdata, vecs[i].lrd);
      next_cycle();
    end

    // Both held 10 cycles: L,L,L,L,F,L,L,L,L,F.
    run_pat("starve", 16'h03FF, 16'h0210, 10);
    // Dropping f_req for one cycle restarts the starvation count.
    run_pat("clear", 16'h00FB, 16'h0080, 8);

    // Reset while a fetch response is in flight.
    drive(1'b1, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("rmf_fgnt", 32'(f_gnt), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    drive(1'b1, 32'd3, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rmf_rst%0d_ctl", i), 32'(ctl_now()), 32'd0);
      chk($sformatf("rmf_rst%0d_fi", i), f_inst, 32'd0);
      next_cycle();
    end
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rmf_post%0d_ctl", i), 32'(ctl_now()), 32'd0);
      chk($sformatf("rmf_post%0d_data", i), f_inst | l_rdata, 32'd0);
      next_cycle();
    end
    // Address 7 must still hold its original value: no write happened in reset.
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd7, 32'd0);
    @(negedge clk);
    chk("rmf_rd_ctl", 32'(ctl_now()), 32'b0110_0000);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("rmf_rd_lv", 32'(l_valid), 32'd1);
    chk("rmf_rd_data", l_rdata, 32'hA000_0007);
    next_cycle();

    // Build up some starvation count, then go idle for 20 cycles.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'd1, 1'b1, 1'b0, 32'd10, 32'd0);
      @(negedge clk);
      chk($sformatf("pre_idle%0d_lg", i), 32'({f_gnt, l_gnt}), 32'b01);
      next_cycle();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("pre_idle_lv", 32'(l_valid), 32'd1);
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), 32'({m_en, m_we, f_gnt, l_gnt, f_valid, l_valid}), 32'd0);
      next_cycle();
    end
    chk("idle_starve_cnt", 32'(dut.starve_cnt_q), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DEPTH, default 128, number of 32-bit words in the instruction memory.
REQ-002 Parameter ADDR_W, default 7, memory address width (log2 DEPTH).
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive loader grants while fetch is pending.
REQ-004 clk  input  1  single clock; all logic is updated on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 f_req  input  1  fetch request.
REQ-007 f_addr  input  32  fetch word address (the pc value, word-indexed).
REQ-008 f_gnt  output  1  fetch request accepted this cycle.
REQ-009 f_valid  output  1  fetch data valid.
REQ-010 f_inst  output  32  fetched instruction.
REQ-011 f_err  output  1  fetch address was out of range; qualified by f_valid.
REQ-012 l_req  input  1  loader/debug request.
REQ-013 l_we  input  1  loader write (1) or read (0).
REQ-014 l_addr  input  32  loader word address.
REQ-015 l_wdata  input  32  loader write data.
REQ-016 l_gnt  output  1  loader request accepted this cycle.
REQ-017 l_valid  output  1  loader read data valid, or write acknowledge.
REQ-018 l_rdata  output  32  loader read data; 0 for writes.
REQ-019 l_err  output  1  loader address was out of range; qualified by l_valid.
REQ-020 m_en, m_we  output  1 each  memory access enable and write enable.
REQ-021 m_addr  output  ADDR_W  memory address; m_wdata  output  32  memory write data.
REQ-022 m_rdata  input  32  memory read data, valid one cycle after m_en with m_we=0.

Function
REQ-023 The arbiter SHALL grant at most one requester per cycle: f_gnt and l_gnt are combinational from the request inputs and the registered arbitration state, and are never both 1.
REQ-024 Priority: the loader wins, except when starve_cnt == STARVE_MAX and f_req=1; fetch then wins for that cycle.
REQ-025 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment on each l_gnt while f_req=1, clear on any f_gnt, clear when f_req=0, and saturate at STARVE_MAX.
REQ-026 On a grant with address < DEPTH, the arbiter SHALL drive m_en=1, m_addr=addr[ADDR_W-1:0], m_we=l_we for the loader and m_we=0 for fetch, and m_wdata=l_wdata; with no grant, m_en=0 and m_we=0.
REQ-027 On a grant with address >= DEPTH, the arbiter SHALL keep m_en=0 and flag an error response.
REQ-028 Response pipeline: registered owner state RSP_IDLE/RSP_FETCH/RSP_LOAD plus an error bit; the next state is set by the grant in the current cycle (none -> RSP_IDLE).
REQ-029 Latency is exactly 1 cycle from grant to the valid output: RSP_FETCH -> f_valid=1, f_inst=m_rdata (0 if error), f_err=error bit.
REQ-030 RSP_LOAD -> l_valid=1; l_rdata=m_rdata for reads, 0 for writes or errors; l_err=error bit.
REQ-031 The valid outputs SHALL be single-cycle pulses, and back-to-back grants SHALL give back-to-back valids (full throughput).
REQ-032 A write granted in cycle N followed by a read of the same address in cycle N+1 SHALL return the new data; this relies on the memory being write-before-read across cycles and needs no bypass.
REQ-033 A request with req deasserted before its grant is dropped; no request is queued.

Reset
REQ-034 While rst_n=0 at a rising edge, the block SHALL set the response state to RSP_IDLE, the error bit to 0, and starve_cnt to 0.
REQ-035 During reset, f_gnt, l_gnt, m_en and m_we SHALL be 0 regardless of requests, and no memory write may occur.
REQ-036 During reset, f_valid, l_valid, f_err and l_err SHALL be 0, and f_inst and l_rdata SHALL be 0.
REQ-037 If reset is asserted while a response is in flight, that response SHALL be discarded, with no valid pulse after reset.

Verification
REQ-038 Fetch only: memory word 0 = 32'h8c060000, f_req=1, f_addr=0 -> f_gnt the same cycle; next cycle f_valid=1, f_inst=32'h8c060000, f_err=0.
REQ-039 Load then fetch: loader writes 32'h00661820 to address 2 in cycle N, then fetch of address 2 in cycle N+1 -> f_inst=32'h00661820 in cycle N+2.
REQ-040 Starvation: l_req and f_req held high for 10 cycles -> grant pattern L,L,L,L,F,L,L,L,L,F, and the f_valid pulses arrive one cycle after each F grant.
REQ-041 Out of range: f_addr=128 -> m_en=0; next cycle f_valid=1, f_err=1, f_inst=0.
REQ-042 Reset mid-flight: fetch granted in cycle N, rst_n=0 in cycle N+1 -> f_valid=0 in cycle N+1, and all outputs stay 0 until the first grant after reset release.
REQ-043 Idle: no requests for 20 cycles -> m_en, all grants and all valids stay 0, and starve_cnt=0.
